// File: rtl/wb_sram16.sv
// rtl/wb_sram16.sv - Wishbone classic 32-bit slave to 16-bit async SRAM bridge.
// Optional WB_SRAM16_SKIP_EN: writes bypass halves whose byte selects are all zero.
module wb_sram16 #(
   parameter int sram_adr_w  = 19,
   parameter int wait_cycles = 2
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic [31:0]           wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   output logic [31:0]           wb_dat_o,
   input  logic [3:0]            wb_sel_i,
   input  logic [2:0]            wb_cti_i,
   input  logic                  wb_we_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   output logic                  wb_ack_o,
   output logic [sram_adr_w-1:0] sram_a,
   output logic [15:0]           sram_d_o,
   input  logic [15:0]           sram_d_i,
   output logic                  sram_d_oe,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic                  sram_ub_n,
   output logic                  sram_lb_n
);

   localparam int cnt_w = $clog2(wait_cycles + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      H_ACC = 3'd1,
      H_REC = 3'd2,
      L_ACC = 3'd3,
      L_REC = 3'd4,
      ACK   = 3'd5
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [sram_adr_w-2:0] word_q;
   logic [31:0]           wdat_q;
   logic [3:0]            sel_q;
   logic                  we_q;
   logic [cnt_w-1:0]      cnt_q;
   logic [15:0]           rd_hi_q;

   logic req;
   logic last;
   logic skip_h_req;
   logic skip_l_req;
   logic skip_l_q;

   // Classic-only: burst tags and sub-word address bits carry no information here.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, wb_cti_i, wb_adr_i[1:0], wb_adr_i[31:sram_adr_w+1]};

   assign req  = wb_cyc_i & wb_stb_i;
   assign last = (cnt_q == cnt_w'(1));

`ifdef WB_SRAM16_SKIP_EN
   assign skip_h_req = wb_we_i & ~|wb_sel_i[3:2];
   assign skip_l_req = wb_we_i & ~|wb_sel_i[1:0];
   assign skip_l_q   = we_q & ~|sel_q[1:0];
`else
   assign skip_h_req = 1'b0;
   assign skip_l_req = 1'b0;
   assign skip_l_q   = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (skip_h_req) begin
                  state_d = skip_l_req ? ACK : L_ACC;
               end else begin
                  state_d = H_ACC;
               end
            end
         end
         H_ACC: begin
            if (last) begin
               state_d = we_q ? H_REC : L_ACC;
            end
         end
         H_REC:   state_d = skip_l_q ? ACK : L_ACC;
         L_ACC: begin
            if (last) begin
               state_d = we_q ? L_REC : ACK;
            end
         end
         L_REC:   state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A master dropping cyc abandons the access from any busy state.
      if (state_q != IDLE && !wb_cyc_i) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         word_q   <= '0;
         wdat_q   <= '0;
         sel_q    <= '0;
         we_q     <= 1'b0;
         cnt_q    <= '0;
         rd_hi_q  <= '0;
         wb_dat_o <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  word_q <= wb_adr_i[sram_adr_w:2];
                  wdat_q <= wb_dat_i;
                  sel_q  <= wb_sel_i;
                  we_q   <= wb_we_i;
                  cnt_q  <= cnt_w'(wait_cycles);
               end
            end
            H_ACC, L_ACC: begin
               if (!wb_cyc_i) begin
                  cnt_q <= '0;
               end else if (last) begin
                  cnt_q <= cnt_w'(wait_cycles);
                  // Upper half is staged so wb_dat_o only changes as ACK begins.
                  if (!we_q && state_q == H_ACC) begin
                     rd_hi_q <= sram_d_i;
                  end
                  if (!we_q && state_q == L_ACC) begin
                     wb_dat_o <= {rd_hi_q, sram_d_i};
                  end
               end else begin
                  cnt_q <= cnt_q - cnt_w'(1);
               end
            end
            ACK: begin
               cnt_q <= '0;
            end
            default: begin
               if (!wb_cyc_i) begin
                  cnt_q <= '0;
               end
            end
         endcase
      end
   end

   always_comb begin
      wb_ack_o  = 1'b0;
      sram_a    = '0;
      sram_d_o  = '0;
      sram_d_oe = 1'b0;
      sram_ce_n = 1'b1;
      sram_oe_n = 1'b1;
      sram_we_n = 1'b1;
      sram_ub_n = 1'b1;
      sram_lb_n = 1'b1;
      case (state_q)
         H_ACC, H_REC: begin
            sram_a    = {word_q, 1'b0};
            sram_d_o  = wdat_q[31:16];
            sram_ub_n = ~sel_q[3];
            sram_lb_n = ~sel_q[2];
            sram_ce_n = 1'b0;
            sram_d_oe = we_q;
            if (state_q == H_ACC) begin
               sram_oe_n = we_q;
               sram_we_n = ~we_q;
            end
         end
         L_ACC, L_REC: begin
            sram_a    = {word_q, 1'b1};
            sram_d_o  = wdat_q[15:0];
            sram_ub_n = ~sel_q[1];
            sram_lb_n = ~sel_q[0];
            sram_ce_n = 1'b0;
            sram_d_oe = we_q;
            if (state_q == L_ACC) begin
               sram_oe_n = we_q;
               sram_we_n = ~we_q;
            end
         end
         ACK: begin
            wb_ack_o = 1'b1;
         end
         default: begin
            wb_ack_o = 1'b0;
         end
      endcase
   end

endmodule
